// File: rtl/cycle_sequencer_pkg.sv
// Shared definitions for the instruction-cycle sequencer: subcycle codes,
// idle RAM strobe pattern and the run/halt state encoding.
package cycle_sequencer_pkg;

    localparam logic [2:0] SC_A1 = 3'd0;
    localparam logic [2:0] SC_A2 = 3'd1;
    localparam logic [2:0] SC_A3 = 3'd2;
    localparam logic [2:0] SC_M1 = 3'd3;
    localparam logic [2:0] SC_M2 = 3'd4;
    localparam logic [2:0] SC_X1 = 3'd5;
    localparam logic [2:0] SC_X2 = 3'd6;
    localparam logic [2:0] SC_X3 = 3'd7;

    // Widest RAM strobe bus supported; instances slice the low bits.
    localparam int unsigned RAM_CMD_MAX_W = 16;
    localparam logic [RAM_CMD_MAX_W-1:0] RAM_CMD_IDLE = '1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_e;

endpackage

// File: rtl/cycle_sequencer_subcycle_counter.sv
// 3-bit subcycle counter (A1..X3) with hold; exposes its next value so the
// sequencer can register strobes aligned with the cycle they belong to.
module subcycle_counter
    import cycle_sequencer_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       hold_i,
    output logic [2:0] cycle_o,
    output logic [2:0] cycle_nxt_c,
    output logic       frame_end_c
);

    logic [2:0] cycle_q;
    logic [2:0] cycle_d;

    // Advance one subcycle per clock, wrapping X3 -> A1, unless held.
    always_comb begin
        cycle_d = cycle_q;
        if (!hold_i) begin
            cycle_d = cycle_q + 3'd1;
        end
    end

    // Counter register; reset parks at A1.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cycle_q <= SC_A1;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    assign cycle_o     = cycle_q;
    assign cycle_nxt_c = cycle_d;
    assign frame_end_c = (cycle_q == SC_X3);

endmodule

// File: rtl/cycle_sequencer.sv
// Instruction-cycle timing controller: 8-subcycle frame, ROM/RAM strobes,
// bus-drive grants and two-word instruction phase tracking.
// Optional halt-at-frame-boundary support: define CYCLE_SEQ_HALT_EN.
module cycle_sequencer
    import cycle_sequencer_pkg::*;
#(
    parameter int unsigned NUM_RAM_BANKS = 4,
    parameter int unsigned SYNC_SUBCYCLE = 7
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [1:0]               ram_select,
    input  logic                     two_word,
    input  logic                     io_op,
`ifdef CYCLE_SEQ_HALT_EN
    input  logic                     halt_req,
`endif
    output logic [2:0]               cycle,
    output logic                     sync,
    output logic                     rom_cmd,
    output logic [NUM_RAM_BANKS-1:0] ram_cmd,
    output logic                     pc_drive,
    output logic                     dp_drive,
    output logic                     inst_phase,
    output logic                     pc_advance,
    output logic                     halted
);

    localparam logic [NUM_RAM_BANKS-1:0] RAM_IDLE = RAM_CMD_IDLE[NUM_RAM_BANKS-1:0];

    logic       start_q;
    logic       hold_c;
    logic       run_d;
    logic [2:0] cycle_nxt_c;
    logic       frame_end_c;

    logic       two_pend_q, two_pend_d;
    logic       inst_phase_q, inst_phase_d;
    logic       io_q, io_d;

    logic                     io_slot_c;
    logic                     mem_strobe_c;
    logic                     sync_q, sync_d;
    logic                     rom_cmd_q, rom_cmd_d;
    logic [NUM_RAM_BANKS-1:0] ram_cmd_q, ram_cmd_d;
    logic                     pc_drive_q, pc_drive_d;
    logic                     dp_drive_q, dp_drive_d;
    logic                     pc_advance_q, pc_advance_d;
    logic                     halted_q, halted_d;

    subcycle_counter u_counter (
        .clk_i       (clock),
        .reset_i     (reset),
        .hold_i      (hold_c),
        .cycle_o     (cycle),
        .cycle_nxt_c (cycle_nxt_c),
        .frame_end_c (frame_end_c)
    );

`ifdef CYCLE_SEQ_HALT_EN
    seq_state_e state_q, state_d;

    // Halt decision is taken only at the frame boundary; release on any clock.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (frame_end_c && halt_req) state_d = ST_HALT;
            ST_HALT: if (!halt_req)               state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // Run/halt state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign run_d  = (state_d == ST_RUN);
    assign hold_c = start_q || (state_q == ST_HALT);
`else
    assign run_d  = 1'b1;
    assign hold_c = start_q;
`endif

    // Phase and io latches: sampled in phase 0 only, retired at frame end.
    always_comb begin
        two_pend_d   = two_pend_q;
        inst_phase_d = inst_phase_q;
        io_d         = io_q;
        if (cycle == SC_M2 && !inst_phase_q) begin
            two_pend_d = two_word;
        end
        if (cycle == SC_X1 && !inst_phase_q) begin
            io_d = io_op;
        end
        if (frame_end_c) begin
            inst_phase_d = two_pend_q;
            two_pend_d   = 1'b0;
            io_d         = 1'b0;
        end
    end

    // Strobe and grant decode from the next subcycle so outputs line up with cycle.
    always_comb begin
        io_slot_c    = (cycle_nxt_c == SC_X2) && io_d;
        mem_strobe_c = run_d && ((cycle_nxt_c == SC_A3) || io_slot_c);
        sync_d       = run_d && (cycle_nxt_c == 3'(SYNC_SUBCYCLE));
        rom_cmd_d    = !mem_strobe_c;
        pc_drive_d   = run_d && (cycle_nxt_c <= SC_A3);
        dp_drive_d   = run_d && io_slot_c;
        pc_advance_d = run_d && (cycle_nxt_c == SC_X3);
        halted_d     = !run_d;
        ram_cmd_d    = RAM_IDLE;
        for (int unsigned i = 0; i < NUM_RAM_BANKS; i++) begin
            if (mem_strobe_c && (32'(ram_select) == i)) begin
                ram_cmd_d[i] = 1'b0;
            end
        end
    end

    // Latches and registered outputs; the first clock after reset is a held A1.
    always_ff @(posedge clock) begin
        if (reset) begin
            start_q      <= 1'b1;
            two_pend_q   <= 1'b0;
            inst_phase_q <= 1'b0;
            io_q         <= 1'b0;
            sync_q       <= 1'b0;
            rom_cmd_q    <= 1'b1;
            ram_cmd_q    <= RAM_IDLE;
            pc_drive_q   <= 1'b0;
            dp_drive_q   <= 1'b0;
            pc_advance_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            start_q      <= 1'b0;
            two_pend_q   <= two_pend_d;
            inst_phase_q <= inst_phase_d;
            io_q         <= io_d;
            sync_q       <= sync_d;
            rom_cmd_q    <= rom_cmd_d;
            ram_cmd_q    <= ram_cmd_d;
            pc_drive_q   <= pc_drive_d;
            dp_drive_q   <= dp_drive_d;
            pc_advance_q <= pc_advance_d;
            halted_q     <= halted_d;
        end
    end

    assign sync       = sync_q;
    assign rom_cmd    = rom_cmd_q;
    assign ram_cmd    = ram_cmd_q;
    assign pc_drive   = pc_drive_q;
    assign dp_drive   = dp_drive_q;
    assign inst_phase = inst_phase_q;
    assign pc_advance = pc_advance_q;
    assign halted     = halted_q;

endmodule
